// File: rtl/imm_encode_if.sv
// imm_encode_if: request and packed-word handshake bundle
// for the immediate packer (master = loader, slave = packer).
interface imm_encode_if #(
  parameter int ADDR_W = 10
) ();
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       imm_val;
  logic [2:0]        imm_src;
  logic [31:0]       base_instr;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       instr;
  logic [ADDR_W-1:0] out_addr;
  logic              range_err;
  logic              chk_err;

  modport master (
    output in_valid, imm_val, imm_src,
    output base_instr, out_ready,
    input  in_ready, out_valid, instr,
    input  out_addr, range_err, chk_err
  );

  modport slave (
    input  in_valid, imm_val, imm_src,
    input  base_instr, out_ready,
    output in_ready, out_valid, instr,
    output out_addr, range_err, chk_err
  );
endinterface

// File: rtl/imm_encode.sv
// imm_encode: scatters an immediate into an RV32 word, multicycle.
// Define IMM_ENCODE_SELFCHECK_EN to add the re-decode VERIFY state.
module imm_encode #(
  parameter int ADDR_W    = 10,
  parameter int ADDR_BASE = 0,
  parameter int STRIDE    = 4
) (
  input logic clk,
  input logic reset,
  imm_encode_if.slave bus
);
  localparam logic [2:0] F_I  = 3'b000;
  localparam logic [2:0] F_B  = 3'b001;
  localparam logic [2:0] F_S  = 3'b010;
  localparam logic [2:0] F_SH = 3'b011;
  localparam logic [2:0] F_U  = 3'b100;
  localparam logic [2:0] F_J  = 3'b101;

  typedef enum logic [2:0] {
    IDLE, CHECK, PACK, VERIFY, DONE
  } state_t;

  state_t            st;
  state_t            nxt;
  logic [31:0]       imm_q;
  logic [2:0]        src_q;
  logic [31:0]       base_q;
  logic [31:0]       instr_q;
  logic              rerr_q;
  logic [ADDR_W-1:0] addr_q;

  // True when v is a sign-extended n-bit quantity.
  function automatic logic fits(
    input logic [31:0] v,
    input int          n
  );
    logic [31:0] t;
    t = $signed(v) >>> (n - 1);
    return (t == '0) || (t == '1);
  endfunction

  function automatic logic range_bad(
    input logic [31:0] v,
    input logic [2:0]  f
  );
    logic bad;
    unique case (f)
      F_I, F_S: bad = !fits(v, 12);
      F_B:      bad = !fits(v, 13) || v[0];
      F_SH:     bad = (v[31:5] != '0);
      F_U:      bad = !fits(v, 20);
      F_J:      bad = !fits(v, 21) || v[0];
      default:  bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [31:0] pack(
    input logic [31:0] b,
    input logic [31:0] v,
    input logic [2:0]  f
  );
    logic [31:0] w;
    w = b;
    unique case (f)
      F_I: w[31:20] = v[11:0];
      F_S: begin
        w[31:25] = v[11:5];
        w[11:7]  = v[4:0];
      end
      F_B: begin
        w[31]    = v[12];
        w[30:25] = v[10:5];
        w[11:8]  = v[4:1];
        w[7]     = v[11];
      end
      F_SH: w[24:20] = v[4:0];
      F_U:  w[31:12] = v[19:0];
      F_J: begin
        w[31]    = v[20];
        w[30:21] = v[10:1];
        w[20]    = v[11];
        w[19:12] = v[19:12];
      end
      default: ;
    endcase
    return w;
  endfunction

`ifdef IMM_ENCODE_SELFCHECK_EN
  logic cerr_q;

  function automatic logic decode_bad(
    input logic [31:0] w,
    input logic [31:0] v,
    input logic [2:0]  f
  );
    logic bad;
    unique case (f)
      F_I: bad = {{20{w[31]}}, w[31:20]} != v;
      F_S: bad = {{20{w[31]}}, w[31:25], w[11:7]} != v;
      F_B: bad = {{19{w[31]}}, w[31], w[7],
                  w[30:25], w[11:8], 1'b0} != v;
      F_SH: bad = w[24:20] != v[4:0];
      F_U:  bad = w[31:12] != v[19:0];
      F_J: bad = {{11{w[31]}}, w[31], w[19:12],
                  w[20], w[30:21], 1'b0} != v;
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) st <= IDLE;
    else       st <= nxt;
  end

  always_comb begin
    nxt = st;
    unique case (st)
      IDLE:  if (bus.in_valid) nxt = CHECK;
      CHECK: nxt = PACK;
`ifdef IMM_ENCODE_SELFCHECK_EN
      PACK:   nxt = VERIFY;
      VERIFY: nxt = DONE;
`else
      PACK:  nxt = DONE;
`endif
      DONE:  if (bus.out_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    unique case (st)
      IDLE:    bus.in_ready  = 1'b1;
      DONE:    bus.out_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      imm_q   <= '0;
      src_q   <= '0;
      base_q  <= '0;
      instr_q <= '0;
      rerr_q  <= 1'b0;
      addr_q  <= ADDR_W'(ADDR_BASE);
    end else begin
      if (st == IDLE && bus.in_valid) begin
        imm_q  <= bus.imm_val;
        src_q  <= bus.imm_src;
        base_q <= bus.base_instr;
      end
      if (st == CHECK)
        rerr_q <= range_bad(imm_q, src_q);
      if (st == PACK)
        instr_q <= pack(base_q, imm_q, src_q);
      if (st == DONE && bus.out_ready)
        addr_q <= addr_q + ADDR_W'(STRIDE);
    end
  end

`ifdef IMM_ENCODE_SELFCHECK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cerr_q <= 1'b0;
    else if (st == CHECK)
      cerr_q <= 1'b0;
    else if (st == VERIFY)
      cerr_q <= !rerr_q &&
                decode_bad(instr_q, imm_q, src_q);
  end
  assign bus.chk_err = cerr_q;
`else
  assign bus.chk_err = 1'b0;
`endif

  assign bus.instr     = instr_q;
  assign bus.range_err = rerr_q;
  assign bus.out_addr  = addr_q;
endmodule

// File: doc/imm_encode.md
Name: imm_encode

Overview:
Inverse of the immediate-extend path. It takes a 32-bit immediate value, an immediate-format select (same 3-bit imm_src encoding the control unit drives) and a base instruction word. It scatters the immediate into that format's bit fields, checks range and alignment, and presents the packed word with an auto-incrementing instruction-memory write address. It runs as a small multicycle FSM with valid/ready on both sides, and is used by the bootloader/test-program loader to build instruction memory contents in hardware.

Parameters:
ADDR_W, 10, width of out_addr (byte address)
ADDR_BASE, 0, out_addr value after reset
STRIDE, 4, out_addr increment per completed output handshake

Ports:
clk  input  1  clock, rising-edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  request valid
in_ready  output  1  block can accept a request
imm_val  input  32  immediate value (two's complement)
imm_src  input  3  format: 000 I, 001 B, 010 S, 011 shamt, 100 U, 101 J, 110/111 illegal
base_instr  input  32  opcode/rd/rs/funct fields; immediate bit positions are overwritten
out_valid  output  1  packed word valid
out_ready  input  1  consumer accepts packed word
instr  output  32  packed instruction word
out_addr  output  ADDR_W  write address paired with instr
range_err  output  1  immediate not representable, or imm_src illegal; qualified by out_valid
chk_err  output  1  self-check mismatch (see Optional Feature); tied 0 when the feature is compiled out

Behaviour:
- Reset (asynchronous, any state): state=IDLE, in_ready=1, out_valid=0, instr=0, range_err=0, chk_err=0, out_addr=ADDR_BASE.
- FSM: IDLE -> CHECK -> PACK -> DONE -> IDLE.
- IDLE: in_ready=1. On in_valid&&in_ready, register imm_val, imm_src, base_instr and go to CHECK. in_ready=0 in all other states.
- CHECK (1 cycle): compute and register range_err per format:
  - I and S: -2048..2047.
  - B: -4096..4094 and imm[0]==0.
  - shamt: imm[31:5]==0.
  - U: -524288..524287. The value is the upper-20 field, not pre-shifted.
  - J: -1048576..1048574 and imm[0]==0.
  - 110/111: always an error.
- PACK (1 cycle): instr = base_instr with the format's immediate bits replaced:
  - I: [31:20]=imm[11:0].
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0].
  - B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11].
  - shamt: [24:20]=imm[4:0]; [31:25] kept from base_instr (funct7).
  - U: [31:12]=imm[19:0].
  - J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12].
  - Illegal: instr=base_instr unchanged.
  - Out-of-range values are still packed using the truncated bits. range_err flags the error; no saturation.
- DONE: out_valid=1. instr, range_err and out_addr are held stable until out_valid&&out_ready. On that edge: out_valid=0, out_addr += STRIDE (wraps modulo 2^ADDR_W), go to IDLE.
- Latency: out_valid rises 3 cycles after the accepting edge. Throughput is one word per 4 cycles with out_ready held high.
- in_valid is ignored outside IDLE. A request presented during DONE is not taken until the cycle after the output handshake.
- Reset mid-operation discards the in-flight request. No partial output is produced.

Optional Feature:
Macro IMM_ENCODE_SELFCHECK_EN.
- Defined: adds a VERIFY state between PACK and DONE, so latency becomes 4. VERIFY re-decodes instr with the immediate-extend mapping for the latched imm_src and compares against the latched imm_val:
  - shamt: 5-bit compare.
  - U: 20-bit compare.
  - other formats: full compare.
  - chk_err=1 in DONE on mismatch, and only when range_err=0.
- Undefined: no VERIFY state, latency 3, chk_err constant 0.

Test Plan:
- base_instr=0x00000093, imm_src=000, imm_val=0xFFFFFFFF -> instr=0xFFF00093, range_err=0, out_valid 3 cycles after accept, out_addr=0x000.
- base_instr=0x00000063, imm_src=001, imm_val=0xFFFFFFFC -> instr=0xFE000EE3, range_err=0.
- base_instr=0x000000EF, imm_src=101, imm_val=8 -> instr=0x008000EF. Then imm_val=7, same format -> range_err=1 (odd offset).
- base_instr=0x00000013, imm_src=000, imm_val=2048 -> range_err=1, instr=0x80000013. imm_src=110 -> range_err=1, instr=base_instr.
- Hold out_ready=0 for 5 cycles in DONE -> out_valid, instr and out_addr stable, in_ready=0. Release -> one handshake, next word's out_addr=0x004. With ADDR_W=3 and ADDR_BASE=4, the second word wraps out_addr to 0.
- Assert reset while in PACK -> out_valid=0 immediately, out_addr=ADDR_BASE, in_ready=1 after reset deasserts. The next request completes normally.
